vector_compounder: RTL and testbench
====================================

// Module: vector_compounder
// PURPOSE
//   Inverse of the vector return divider: rebuilds a price vector from base prices and per-lane
//   fixed-point returns, c[i] = a[i]*(1+b[i]), or the scaled product a[i]*b[i].
//   Sits after the returns/covariance path, so strategy outputs in return space map back to prices.
//   One shared signed multiplier processes one lane per cycle under a small FSM.
// PARAMETERS
//   N          4   number of lanes
//   W          16  lane width, signed two's complement
//   FRAC_BITS  13  fraction bits of b (Q(W-FRAC_BITS).FRAC_BITS); 8192 = 1.0
// PORTS
//   clk_100mhz  in   1      system clock, all state on rising edge
//   reset       in   1      asynchronous, active-high; clears all state
//   valid       in   1      request strobe; sampled only in IDLE
//   sel         in   1      1 = compound a*(1+b); 0 = scaled product a*b
//   a           in   W x N  signed [W-1:0] a [0:N-1]; base prices, integer
//   b           in   W x N  signed [W-1:0] b [0:N-1]; returns, Q.FRAC_BITS
//   c           out  W x N  signed [W-1:0] c [0:N-1]; result vector, held until next result
//   ready       out  1      one-cycle pulse; c valid from this cycle onward
//   busy        out  1      high in CALC and DONE; requests are ignored while high
//   sat         out  1      any lane of the current c saturated; updated together with c
// BEHAVIOUR
//   Reset (async): state=IDLE, idx=0, c all 0, ready=0, busy=0, sat=0. Internal result regs = 0.
//   FSM states IDLE -> CALC -> DONE -> IDLE:
//     IDLE: on an edge with valid=1, latch a, b and sel; idx<=0; go to CALC. Otherwise stay.
//     CALC: each edge computes lane idx into the internal result reg; idx++.
//           On the edge that finishes lane N-1, go to DONE.
//     DONE: one edge copies the result regs into c, updates sat, sets ready=1, goes to IDLE.
//   ready is 1 for exactly one cycle; it is cleared on the following edge.
//   Latency: capture edge E; ready and the new c are visible after edge E+N+1 (E+5 for N=4).
//   Throughput: one vector per N+2 cycles. Back-to-back: valid held high is accepted on the edge
//     after ready rises.
//   Inputs a, b and sel may change after the capture edge; only the latched copies are used.
//   Per-lane arithmetic:
//     p   = a*b                              full 2W-bit signed product
//     d   = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS   arithmetic shift; round half toward +inf
//     r   = sel ? a + d : d                  computed at W+FRAC_BITS+1 bits, no wrap
//     c   = r clamped to [-2^(W-1), 2^(W-1)-1]
//   sat = OR of the per-lane clamp events in that job.
//   No divide-by-zero or undefined case exists: every input value is legal.
//   Reset mid-operation: the in-flight job is discarded. No ready pulse is produced, c returns to 0,
//     and the next valid after reset deassertion starts a fresh job.
//   valid while busy=1: ignored and not queued.
// TESTING
//   1 a={100,200,300,400}, b=819 all lanes, sel=1
//     -> c={110,220,330,440}, sat=0, ready 5 edges after capture for 1 cycle
//   2 a={100,200,300,400}, b=-819 all lanes, sel=1
//     -> c={90,180,270,360} (100: d=-10), sat=0
//   3 a={100,-200,0,32767}, b={819,819,8192,0}, sel=0 -> c={10,-20,0,0}, sat=0
//   4 a={30000,-30000,1,1}, b={8192,8192,0,0}, sel=1
//     -> c={32767,-32768,1,1}, sat=1; next clean job clears sat
//   5 reset pulsed 2 edges after capture -> ready never pulses, c=0, busy=0;
//     a new job afterwards completes normally
//   6 valid held high continuously, with a and b changed every cycle
//     -> a job starts on each edge after ready; each c matches the operands at its capture edge;
//        mid-job changes have no effect

Source files
------------

// File: rtl/vector_compounder_if.sv
// Request/result bundle for vector_compounder: operand vectors and strobe in,
// compounded vector plus status out.
interface vector_compounder_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic                valid;
  logic                sel;
  logic signed [W-1:0] a [N];
  logic signed [W-1:0] b [N];
  logic signed [W-1:0] c [N];
  logic                ready;
  logic                busy;
  logic                sat;

  modport master (output valid, sel, a, b, input c, ready, busy, sat);
  modport slave  (input valid, sel, a, b, output c, ready, busy, sat);
endinterface

// File: rtl/vector_compounder.sv
// Rebuilds prices from base prices and fixed-point returns, c = a*(1+b) or a*b,
// one lane per cycle through a single shared signed multiplier.
module vector_compounder #(
  parameter int N         = 4,
  parameter int W         = 16,
  parameter int FRAC_BITS = 13
) (
  input  logic               clk_100mhz,
  input  logic               reset,
  vector_compounder_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W + 1;
  localparam logic [IW-1:0]        LAST = IW'(N - 1);
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (W - 1) - 1);
  localparam logic signed [PW-1:0] MINV = -PW'(2 ** (W - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic signed [W-1:0] a_q [N];
  logic signed [W-1:0] a_d [N];
  logic signed [W-1:0] b_q [N];
  logic signed [W-1:0] b_d [N];
  logic signed [W-1:0] res_q [N];
  logic signed [W-1:0] res_d [N];
  logic signed [W-1:0] c_q [N];
  logic signed [W-1:0] c_d [N];
  logic                sel_q, sel_d;
  logic                acc_sat_q, acc_sat_d;
  logic                sat_q, sat_d;
  logic                ready_q, ready_d;

  logic signed [W-1:0]   a_lane, b_lane, lane_res;
  logic signed [2*W-1:0] prod;
  logic signed [PW-1:0]  scaled, sum;
  logic                  lane_clamp;

  // Shared lane datapath; PW bits hold a + round(a*b) without any wrap.
  always_comb begin
    a_lane     = a_q[idx_q];
    b_lane     = b_q[idx_q];
    prod       = (2 * W)'(a_lane) * (2 * W)'(b_lane);
    scaled     = (PW'(prod) + RND) >>> FRAC_BITS;
    sum        = sel_q ? (scaled + PW'(a_lane)) : scaled;
    lane_clamp = 1'b0;
    lane_res   = sum[W-1:0];
    if (sum > MAXV) begin
      lane_res   = MAXV[W-1:0];
      lane_clamp = 1'b1;
    end else if (sum < MINV) begin
      lane_res   = MINV[W-1:0];
      lane_clamp = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    c_d       = c_q;
    sel_d     = sel_q;
    acc_sat_d = acc_sat_q;
    sat_d     = sat_q;
    ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          a_d       = bus.a;
          b_d       = bus.b;
          sel_d     = bus.sel;
          idx_d     = '0;
          acc_sat_d = 1'b0;
          state_d   = CALC;
        end
      end
      CALC: begin
        res_d[idx_q] = lane_res;
        acc_sat_d    = acc_sat_q | lane_clamp;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        c_d     = res_q;
        sat_d   = acc_sat_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sel_q     <= 1'b0;
      acc_sat_q <= 1'b0;
      sat_q     <= 1'b0;
      ready_q   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
        c_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      acc_sat_q <= acc_sat_d;
      sat_q     <= sat_d;
      ready_q   <= ready_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      c_q       <= c_d;
    end
  end

  assign bus.c     = c_q;
  assign bus.ready = ready_q;
  assign bus.busy  = (state_q == CALC) || (state_q == DONE);
  assign bus.sat   = sat_q;
endmodule

// File: tb/tb_vector_compounder.sv
// Bench for vector_compounder: directed cases plus randomized traffic checked
// every cycle against a job-level arithmetic model.
module tb_vector_compounder;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int FB = 13;

  typedef logic signed [W-1:0] vec_t [N];

  logic clk_100mhz = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_100mhz = ~clk_100mhz;

  vector_compounder_if #(.N(N), .W(W)) vif ();

  vector_compounder #(.N(N), .W(W), .FRAC_BITS(FB)) dut (
    .clk_100mhz(clk_100mhz),
    .reset     (reset),
    .bus       (vif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Exact rational arithmetic: floor((a*b + half) / 2^FB), optional +a, then clamp.
  function automatic void model_lane(input longint av, input longint bv, input bit s,
                                     output logic signed [W-1:0] cv, output bit sv);
    longint num, d, r, hi, lo;
    num = av * bv + (64'sd1 <<< (FB - 1));
    d   = num / (64'sd1 <<< FB);
    if (num < 0 && (num % (64'sd1 <<< FB)) != 0) d = d - 1;
    r  = s ? av + d : d;
    hi = (64'sd1 <<< (W - 1)) - 1;
    lo = -(64'sd1 <<< (W - 1));
    sv = (r > hi) || (r < lo);
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    cv = r[W-1:0];
  endfunction

  // Job-level reference: one job in flight, result due N+1 edges after capture.
  int   edge_n    = 0;
  int   free_edge = 0;
  int   job_cap   = 0;
  bit   job_act   = 1'b0;
  bit   job_sat   = 1'b0;
  bit   exp_sat   = 1'b0;
  bit   exp_ready = 1'b0;
  bit   exp_busy  = 1'b0;
  vec_t job_c     = '{default: '0};
  vec_t exp_c     = '{default: '0};

  task automatic model_clear();
    job_act   = 1'b0;
    exp_ready = 1'b0;
    exp_busy  = 1'b0;
    exp_sat   = 1'b0;
    free_edge = 0;
    for (int i = 0; i < N; i++) exp_c[i] = '0;
  endtask

  always @(posedge clk_100mhz) begin
    edge_n++;
    exp_ready = 1'b0;
    if (reset) begin
      model_clear();
    end else begin
      if (job_act && edge_n == job_cap + N + 1) begin
        exp_c     = job_c;
        exp_sat   = job_sat;
        exp_ready = 1'b1;
        job_act   = 1'b0;
      end
      if (!job_act && vif.valid && edge_n >= free_edge) begin
        job_sat = 1'b0;
        for (int i = 0; i < N; i++) begin
          logic signed [W-1:0] cv;
          bit sv;
          model_lane(longint'(vif.a[i]), longint'(vif.b[i]), vif.sel, cv, sv);
          job_c[i] = cv;
          job_sat  = job_sat | sv;
        end
        job_cap   = edge_n;
        free_edge = edge_n + N + 2;
        job_act   = 1'b1;
      end
      exp_busy = job_act;
    end
  end

  always @(negedge clk_100mhz) begin
    if (reset) model_clear();
    chk("ready", longint'(vif.ready), longint'(exp_ready));
    chk("busy", longint'(vif.busy), longint'(exp_busy));
    chk("sat", longint'(vif.sat), longint'(exp_sat));
    for (int i = 0; i < N; i++) chk($sformatf("c[%0d]", i), longint'(vif.c[i]), longint'(exp_c[i]));
  end

  // Caller must be idle, positioned just after a rising edge.
  task automatic run_job(input string nm, input vec_t av, input vec_t bv, input bit s,
                         input vec_t ec, input bit es);
    int lat;
    lat       = -1;
    vif.a     = av;
    vif.b     = bv;
    vif.sel   = s;
    vif.valid = 1'b1;
    @(posedge clk_100mhz);
    #1;
    vif.valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      vif.a[k] = W'($urandom);
      vif.b[k] = W'($urandom);
    end
    vif.sel = ~s;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_100mhz);
      #1;
      if (vif.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, lat, N + 1);
    for (int i = 0; i < N; i++) chk($sformatf("%s_c%0d", nm, i), longint'(vif.c[i]), longint'(ec[i]));
    chk({nm, "_sat"}, longint'(vif.sat), longint'(es));
    @(posedge clk_100mhz);
    #1;
    chk({nm, "_ready_pulse"}, longint'(vif.ready), 0);
  endtask

  function automatic logic signed [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'sh7FFF;
      1: return 16'sh8000;
      2: return '0;
      3: return 16'sd8192;
      4: return -16'sd8192;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      vif.a[i] = pick();
      vif.b[i] = pick();
    end
    vif.sel = 1'($urandom);
  endtask

  initial begin
    logic signed [W-1:0] pc;
    bit ps;
    bit saw;
    vif.valid = 1'b0;
    vif.sel   = 1'b0;
    for (int i = 0; i < N; i++) begin
      vif.a[i] = '0;
      vif.b[i] = '0;
    end

    model_lane(100, -819, 1'b1, pc, ps);  chk("pin_neg_ret", pc, 90);
    model_lane(-1, 4096, 1'b0, pc, ps);   chk("pin_half_down", pc, 0);
    model_lane(1, 4096, 1'b0, pc, ps);    chk("pin_half_up", pc, 1);
    model_lane(30000, 8192, 1'b1, pc, ps);
    chk("pin_clamp_val", pc, 32767);
    chk("pin_clamp_sat", ps, 1);

    repeat (3) @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    chk("reset_busy", longint'(vif.busy), 0);
    chk("reset_c0", longint'(vif.c[0]), 0);
    @(posedge clk_100mhz);
    #1;

    run_job("t1", '{100, 200, 300, 400}, '{819, 819, 819, 819}, 1'b1, '{110, 220, 330, 440}, 1'b0);
    run_job("t2", '{100, 200, 300, 400}, '{-819, -819, -819, -819}, 1'b1, '{90, 180, 270, 360}, 1'b0);
    run_job("t3", '{100, -200, 0, 32767}, '{819, 819, 8192, 0}, 1'b0, '{10, -20, 0, 0}, 1'b0);
    run_job("t4", '{30000, -30000, 1, 1}, '{8192, 8192, 0, 0}, 1'b1, '{32767, -32768, 1, 1}, 1'b1);
    run_job("t4_clean", '{100, 200, 300, 400}, '{819, 819, 819, 819}, 1'b1, '{110, 220, 330, 440}, 1'b0);

    // Reset two edges into a job.
    vif.a     = '{1000, 2000, 3000, 4000};
    vif.b     = '{8192, 8192, 8192, 8192};
    vif.sel   = 1'b1;
    vif.valid = 1'b1;
    @(posedge clk_100mhz);
    #1;
    vif.valid = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    #1;
    reset = 1'b1;
    @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    saw   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_100mhz);
      #1;
      saw = saw | (vif.ready === 1'b1);
    end
    chk("t5_no_ready", saw, 0);
    chk("t5_c0_zero", longint'(vif.c[0]), 0);
    chk("t5_busy", longint'(vif.busy), 0);
    run_job("t5_after", '{100, 200, 300, 400}, '{819, 819, 819, 819}, 1'b1, '{110, 220, 330, 440}, 1'b0);

    // Back-to-back with operands changing every cycle.
    vif.valid = 1'b1;
    for (int k = 0; k < 90; k++) begin
      randomize_inputs();
      @(posedge clk_100mhz);
      #1;
    end
    vif.valid = 1'b0;
    repeat (10) @(posedge clk_100mhz);
    #1;

    // Sparse random requests.
    for (int k = 0; k < 600; k++) begin
      randomize_inputs();
      vif.valid = ($urandom_range(0, 3) == 0);
      @(posedge clk_100mhz);
      #1;
    end
    vif.valid = 1'b0;
    repeat (10) @(posedge clk_100mhz);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
